// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, LSU state encoding and the access legality/alignment check
package lsu_pkg;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} lsu_state_t;
  function automatic logic lsu_bad(input logic write, input logic [2:0] f3, input logic [1:0] off);
    return (write ? f3 > F3_W : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      || (f3[1:0] == F3_H[1:0] && off[0]) || (f3[1:0] == F3_W[1:0] && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane merge (i_word+i_wdata -> o_merged) and load extract/extend (i_word -> o_load) by i_f3/i_off
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);
  logic [4:0] w_sh;
  logic [31:0] w_mask;
  logic [15:0] w_sft;
  logic w_word;
  assign w_word = i_f3[1:0] == F3_W[1:0];
  assign w_sh = i_f3[0] ? {i_off[1], 4'b0} : {i_off, 3'b0};
  assign w_mask = w_word ? '1 : (i_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
  assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  assign w_sft = 16'(i_word >> w_sh);
  assign o_load = w_word ? i_word
    : i_f3[0] ? {{16{~i_f3[2] & w_sft[15]}}, w_sft}
    : {{24{~i_f3[2] & w_sft[7]}}, w_sft[7:0]};
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage FSM; req_* handshake in, mem_* read/RMW-write strobes out, wb_* one-cycle result pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);
  lsu_state_t r_state, w_next;
  logic [2:0] r_cnt, r_f3;
  logic [31:0] r_addr, r_wdata, r_word, w_merged, w_load;
  logic [4:0] r_rd;
  logic r_write, r_err, w_acc, w_bad, w_done, w_ok;
  assign w_acc = req_valid && req_ready;
  assign w_bad = lsu_bad(req_write, req_funct3, req_addr[1:0]);
  assign w_done = r_state == S_READ && r_cnt == 3'(MEM_LAT);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_next = w_bad ? S_RESP : (req_write && req_funct3 == F3_W) ? S_WRITE : S_READ;
      S_READ: if (w_done) w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt <= '0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_word <= '0;
      r_rd <= '0;
      r_write <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_state == S_READ ? r_cnt + 3'd1 : 3'd0;
      if (w_acc) begin
        r_f3 <= req_funct3;
        r_addr <= req_addr;
        r_wdata <= req_wdata;
        r_rd <= req_rd;
        r_write <= req_write;
        r_err <= w_bad;
      end
      if (w_done) r_word <= mem_rdata;
    end
  lsu_align u_align (
    .i_word(r_word),
    .i_wdata(r_wdata),
    .i_f3(r_f3),
    .i_off(r_addr[1:0]),
    .o_merged(w_merged),
    .o_load(w_load)
  );
  assign req_ready = !reset && r_state == S_IDLE;
  assign mem_read = !reset && r_state == S_READ;
  assign mem_write = !reset && r_state == S_WRITE;
  assign mem_addr = reset ? '0 : {r_addr[31:2], 2'b00};
  assign mem_wdata = mem_write ? w_merged : '0;
  assign wb_valid = !reset && r_state == S_RESP;
  assign wb_err = wb_valid && r_err;
  assign w_ok = wb_valid && !r_err && !r_write;
  assign wb_rd = w_ok ? r_rd : '0;
  assign wb_data = w_ok ? w_load : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: reference-model bench for load_store_unit (MEM_LAT=1 main, MEM_LAT=3 directed)
module tb_load_store_unit;
  localparam int LAT = 1;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, v3 = 1'b0, req_write = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, mem_read, mem_write, wb_valid, wb_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0] wb_rd;
  logic req_ready_3, mem_read_3, mem_write_3, wb_valid_3, wb_err_3;
  logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3, wb_data_3;
  logic [4:0] wb_rd_3;
  load_store_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );
  load_store_unit #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(req_ready_3), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_read(mem_read_3), .mem_write(mem_write_3),
    .mem_rdata(mem_rdata_3), .wb_valid(wb_valid_3), .wb_rd(wb_rd_3), .wb_data(wb_data_3), .wb_err(wb_err_3)
  );

  logic [31:0] mem1 [16], mem3 [16], init1 [16], ref_mem [16];
  int rc1 = 0, rc3 = 0;
  bit loaded = 0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= init1[i];
        mem3[i] <= (i == 5) ? 32'h89AB_CDEF : 32'h0;
      end
      loaded <= 1;
    end else begin
      if (mem_write) mem1[mem_addr[5:2]] <= mem_wdata;
      if (mem_write_3) mem3[mem_addr_3[5:2]] <= mem_wdata_3;
    end
    rc1 <= mem_read ? rc1 + 1 : 0;
    rc3 <= mem_read_3 ? rc3 + 1 : 0;
  end
  assign mem_rdata = (mem_read && rc1 >= LAT) ? mem1[mem_addr[5:2]] : 32'hDEAD_BEEF;
  assign mem_rdata_3 = (mem_read_3 && rc3 >= 3) ? mem3[mem_addr_3[5:2]] : 32'hDEAD_BEEF;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic bit bad(input logic w, input logic [2:0] f, input logic [31:0] a);
    bit legal;
    int sz;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f[1:0];
    return !legal || (a % sz != 0);
  endfunction

  bit pend = 0;
  int p_cyc, acc_cyc, n_rd, n_wr, last_lat;
  logic p_write, last_err;
  logic [2:0] p_f3;
  logic [31:0] p_addr, p_wdata, last_data;
  logic [4:0] p_rd, last_rd;

  task automatic check_resp();
    logic [31:0] old, nw, ld;
    logic [7:0] by [4];
    int v, off, idx;
    bit e;
    idx = int'(p_addr[5:2]);
    old = ref_mem[idx];
    off = int'(p_addr % 4);
    e = bad(p_write, p_f3, p_addr);
    nw = old;
    ld = '0;
    if (!e && p_write) begin
      for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
      by[off] = p_wdata[7:0];
      if (p_f3 == 3'd1) by[off+1] = p_wdata[15:8];
      nw = (p_f3 == 3'd2) ? p_wdata : {by[3], by[2], by[1], by[0]};
    end
    if (!e && !p_write) begin
      if (p_f3[1:0] == 2'd0) begin
        v = int'((old >> (8 * off)) & 32'hFF);
        if (!p_f3[2] && v > 127) v -= 256;
      end else if (p_f3[1:0] == 2'd1) begin
        v = int'((old >> (8 * off)) & 32'hFFFF);
        if (!p_f3[2] && v > 32767) v -= 65536;
      end else v = int'(old);
      ld = 32'(v);
    end
    chk("wb_err", 32'(wb_err), 32'(e));
    chk("wb_rd", 32'(wb_rd), (e || p_write) ? 32'h0 : 32'(p_rd));
    chk("wb_data", wb_data, ld);
    chk("mem_word", mem1[idx], nw);
    chk("n_read", 32'(n_rd), (e || (p_write && p_f3 == 3'd2)) ? 32'h0 : 32'(LAT + 1));
    chk("n_write", 32'(n_wr), 32'(!e && p_write));
    ref_mem[idx] = nw;
    last_data = wb_data;
    last_rd = wb_rd;
    last_err = wb_err;
    last_lat = cyc - acc_cyc;
  endtask

  always @(negedge clk) begin
    bit rdy, e;
    if (reset) begin
      chk("reset_outputs", 32'({req_ready, mem_read, mem_write, wb_valid, wb_err, wb_rd,
        |mem_addr, |mem_wdata, |wb_data}), 32'h0);
      pend = 0;
    end else begin
      rdy = !pend;
      chk("req_ready", 32'(req_ready), 32'(rdy));
      chk("rw_exclusive", 32'(mem_read && mem_write), 32'h0);
      if (!mem_write) chk("wdata_idle", mem_wdata, 32'h0);
      if (pend) begin
        n_rd += int'(mem_read);
        n_wr += int'(mem_write);
        if (mem_read || mem_write) chk("mem_addr", mem_addr, {p_addr[31:2], 2'b00});
      end else chk("stray_strobe", 32'({mem_read, mem_write}), 32'h0);
      chk("wb_valid", 32'(wb_valid), 32'(pend && cyc == p_cyc));
      if (pend && cyc == p_cyc) begin
        check_resp();
        pend = 0;
      end
      if (req_valid && rdy) begin
        pend = 1;
        p_write = req_write;
        p_f3 = req_funct3;
        p_addr = req_addr;
        p_wdata = req_wdata;
        p_rd = req_rd;
        acc_cyc = cyc;
        n_rd = 0;
        n_wr = 0;
        e = bad(req_write, req_funct3, req_addr);
        p_cyc = cyc + (e ? 1 : (req_write && req_funct3 == 3'd2) ? 2 : req_write ? 3 + LAT : 2 + LAT);
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd);
    for (int i = 0; i < 40 && pend; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    req_write = w;
    req_funct3 = f;
    req_addr = a;
    req_wdata = d;
    req_rd = rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!pend) break;
      req_valid = 1'($urandom % 2);
      req_write = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr = 32'($urandom % 64);
      req_wdata = $urandom;
      req_rd = 5'($urandom);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int t0, got, nr3;
    logic [31:0] d3;
    logic [4:0] r3;
    for (int i = 0; i < 16; i++) begin
      init1[i] = $urandom;
      ref_mem[i] = init1[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    do_req(1'b1, 3'd2, 32'd16, 32'h1234_5678, 5'd5);
    chk("sw_mem", mem1[4], 32'h1234_5678);
    chk("sw_lat", 32'(last_lat), 32'd2);
    chk("sw_rd", 32'(last_rd), 32'd0);
    do_req(1'b1, 3'd0, 32'd17, 32'h0000_00EF, 5'd3);
    chk("sb_mem", mem1[4], 32'h1234_EF78);
    chk("sb_lat", 32'(last_lat), 32'd4);
    do_req(1'b0, 3'd0, 32'd17, 32'h0, 5'd9);
    chk("lb_data", last_data, 32'hFFFF_FFEF);
    chk("lb_rd", 32'(last_rd), 32'd9);
    chk("lb_lat", 32'(last_lat), 32'd3);
    do_req(1'b0, 3'd4, 32'd17, 32'h0, 5'd10);
    chk("lbu_data", last_data, 32'h0000_00EF);
    do_req(1'b0, 3'd1, 32'd18, 32'h0, 5'd11);
    chk("lh_data", last_data, 32'h0000_1234);
    chk("lh_lat", 32'(last_lat), 32'd3);
    do_req(1'b0, 3'd2, 32'd18, 32'h0, 5'd12);
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_lat", 32'(last_lat), 32'd1);
    do_req(1'b1, 3'd1, 32'd19, 32'hFFFF, 5'd13);
    chk("sh_mis_err", 32'(last_err), 32'd1);
    chk("sh_mis_lat", 32'(last_lat), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'd0;
    req_addr = 32'd17;
    req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("aborted_sb_mem", mem1[4], 32'h1234_EF78);
    @(posedge clk);
    #1;
    repeat (150) do_req(1'($urandom), 3'($urandom), 32'($urandom % 64), $urandom, 5'($urandom));
    req_write = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'd20;
    req_rd = 5'd7;
    chk("dut3_ready", 32'(req_ready_3), 32'd1);
    v3 = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 v3 = 1'b0;
    got = -1;
    nr3 = 0;
    d3 = '0;
    r3 = '0;
    for (int i = 0; i < 20 && got < 0; i++) begin
      @(negedge clk);
      nr3 += int'(mem_read_3);
      if (wb_valid_3) begin
        got = cyc - t0;
        d3 = wb_data_3;
        r3 = wb_rd_3;
      end
    end
    chk("lat3_wb_cycle", 32'(got), 32'd5);
    chk("lat3_reads", 32'(nr3), 32'd4);
    chk("lat3_data", d3, 32'h89AB_CDEF);
    chk("lat3_rd", 32'(r3), 32'd7);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
